// File: rtl/fp_act_pkg.sv
// Shared encodings and constants for the multi-mode float activation pipeline.
package fp_act_pkg;

    typedef enum logic [1:0] {
        MODE_SIGMOID = 2'd0,
        MODE_TANH    = 2'd1,
        MODE_RELU    = 2'd2,
        MODE_LEAKY   = 2'd3
    } mode_t;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] ONE  = 32'h3F80_0000;

    // PLAN constants held in units of 2^-5, rescaled to the datapath precision below
    localparam int PLAN_Q     = 5;
    localparam int PLAN_BP1   = 32;   // 1.0
    localparam int PLAN_BP2   = 76;   // 2.375
    localparam int PLAN_CLAMP = 160;  // 5.0
    localparam int PLAN_OFF0  = 16;   // 0.5
    localparam int PLAN_OFF1  = 20;   // 0.625
    localparam int PLAN_OFF2  = 27;   // 0.84375
    localparam int PLAN_ONE   = 32;   // 1.0

    function automatic int plan_scale(input int c, input int frac_bits);
        return c << (frac_bits - PLAN_Q);
    endfunction

endpackage

// File: rtl/fp_fix_normalize.sv
// Unsigned fixed-point magnitude to IEEE-754 single: leading-one detect and
// normalise, truncating any bits below the 23-bit mantissa.
module fp_fix_normalize
    import fp_act_pkg::*;
#(
    parameter int FRAC_BITS = 16,
    parameter int W         = 19
) (
    input  logic [W-1:0] i_mag,
    input  logic         i_sign,
    output logic [31:0]  o_float
);

    int          w_lead;
    logic [7:0]  w_exp;
    logic [22:0] w_frac;

    always_comb begin
        w_lead = 0;
        for (int i = 0; i < W; i++) begin
            if (i_mag[i]) w_lead = i;
        end
        w_exp  = 8'(BIAS + w_lead - FRAC_BITS);
        w_frac = 23'({i_mag, 23'd0} >> w_lead);
        if (i_mag == '0) o_float = 32'd0;
        else             o_float = {i_sign, w_exp, w_frac};
    end

endmodule

// File: rtl/fp_activation_pipe.sv
// Four-stage streaming activation unit: sigmoid/tanh through a fixed-point
// PLAN approximation, ReLU/leaky ReLU handled directly on the float encoding.
module fp_activation_pipe
    import fp_act_pkg::*;
#(
    parameter int FRAC_BITS   = 16,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_mode,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam int FX_W = FRAC_BITS + 3;
    localparam logic [FX_W-1:0] FX_BP1   = FX_W'(plan_scale(PLAN_BP1, FRAC_BITS));
    localparam logic [FX_W-1:0] FX_BP2   = FX_W'(plan_scale(PLAN_BP2, FRAC_BITS));
    localparam logic [FX_W-1:0] FX_CLAMP = FX_W'(plan_scale(PLAN_CLAMP, FRAC_BITS));
    localparam logic [FX_W-1:0] FX_OFF0  = FX_W'(plan_scale(PLAN_OFF0, FRAC_BITS));
    localparam logic [FX_W-1:0] FX_OFF1  = FX_W'(plan_scale(PLAN_OFF1, FRAC_BITS));
    localparam logic [FX_W-1:0] FX_OFF2  = FX_W'(plan_scale(PLAN_OFF2, FRAC_BITS));
    localparam logic [FX_W-1:0] FX_ONE   = FX_W'(plan_scale(PLAN_ONE, FRAC_BITS));
    localparam logic [8:0]      EXP_UNIT = 9'(150 - FRAC_BITS);

    logic w_adv;
    logic r_out_valid;
    logic [31:0] r_out_data;

    assign w_adv     = ~r_out_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // S1: unpack, classify, fixed-point magnitude or float bypass result
    mode_t       w_mode;
    logic        w_sign, w_is_nan, w_is_inf, w_is_zero, w_neg, w_byp;
    logic [7:0]  w_exp;
    logic [22:0] w_man;
    logic [8:0]  w_exp_eff;
    logic [63:0] w_shifted;
    logic [FX_W-1:0] w_mag;
    logic [31:0] w_bpd;

    assign w_mode    = mode_t'(in_mode);
    assign w_sign    = in_data[31];
    assign w_exp     = in_data[30:23];
    assign w_man     = in_data[22:0];
    assign w_is_nan  = (w_exp == 8'hFF) && (w_man != '0);
    assign w_is_inf  = (w_exp == 8'hFF) && (w_man == '0);
    assign w_is_zero = (w_exp == 8'h00);
    assign w_neg     = w_sign & ~w_is_zero;

    always_comb begin
        // tanh works on |2x|, folded in as one extra exponent step
        w_exp_eff = {1'b0, w_exp} + ((w_mode == MODE_TANH) ? 9'd1 : 9'd0);
        if (w_exp_eff >= EXP_UNIT) w_shifted = 64'({1'b1, w_man}) << (w_exp_eff - EXP_UNIT);
        else                       w_shifted = 64'({1'b1, w_man}) >> (EXP_UNIT - w_exp_eff);
        if (w_is_zero)                                            w_mag = '0;
        else if (w_exp_eff >= 9'd130 || w_shifted >= 64'(FX_CLAMP)) w_mag = FX_CLAMP;
        else                                                      w_mag = w_shifted[FX_W-1:0];

        w_byp = w_is_nan || (w_mode == MODE_RELU) || (w_mode == MODE_LEAKY);
        w_bpd = 32'd0;
        if (w_is_nan)                   w_bpd = QNAN;
        else if (w_mode == MODE_RELU)   w_bpd = (w_sign || w_is_zero) ? 32'd0 : in_data;
        else if (w_mode == MODE_LEAKY) begin
            if (w_is_zero)                       w_bpd = 32'd0;
            else if (!w_sign || w_is_inf)        w_bpd = in_data;
            else if (w_exp <= 8'(LEAKY_SHIFT))   w_bpd = 32'h8000_0000;
            else                                 w_bpd = {1'b1, w_exp - 8'(LEAKY_SHIFT), w_man};
        end
    end

    logic            r_vld_p1, r_neg_p1, r_byp_p1;
    mode_t           r_mode_p1;
    logic [31:0]     r_bpd_p1;
    logic [FX_W-1:0] r_mag_p1;

    // S2: PLAN segment select, shifts and adds only
    logic [FX_W-1:0] w_y;

    always_comb begin
        if (r_mag_p1 < FX_BP1)        w_y = (r_mag_p1 >> 2) + FX_OFF0;
        else if (r_mag_p1 < FX_BP2)   w_y = (r_mag_p1 >> 3) + FX_OFF1;
        else if (r_mag_p1 < FX_CLAMP) w_y = (r_mag_p1 >> 5) + FX_OFF2;
        else                          w_y = FX_ONE;
    end

    logic            r_vld_p2, r_neg_p2, r_byp_p2;
    mode_t           r_mode_p2;
    logic [31:0]     r_bpd_p2;
    logic [FX_W-1:0] r_y_p2;

    // S3: sigmoid reflection / tanh rescale, sign application
    logic [FX_W-1:0] w_r;
    logic            w_rsign;

    always_comb begin
        w_r     = r_y_p2;
        w_rsign = 1'b0;
        if (r_mode_p2 == MODE_SIGMOID) begin
            if (r_neg_p2) w_r = FX_ONE - r_y_p2;
        end else if (r_mode_p2 == MODE_TANH) begin
            w_r     = (r_y_p2 << 1) - FX_ONE;
            w_rsign = r_neg_p2;
        end
        if (w_r == '0) w_rsign = 1'b0;
    end

    logic            r_vld_p3, r_rsign_p3, r_byp_p3;
    logic [31:0]     r_bpd_p3;
    logic [FX_W-1:0] r_r_p3;

    // S4: pack fixed magnitude back to float
    logic [31:0] w_norm;

    fp_fix_normalize #(
        .FRAC_BITS (FRAC_BITS),
        .W         (FX_W)
    ) u_norm (
        .i_mag   (r_r_p3),
        .i_sign  (r_rsign_p3),
        .o_float (w_norm)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_p1    <= 1'b0;
            r_vld_p2    <= 1'b0;
            r_vld_p3    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
        end else if (w_adv) begin
            r_vld_p1    <= in_valid;
            r_vld_p2    <= r_vld_p1;
            r_vld_p3    <= r_vld_p2;
            r_out_valid <= r_vld_p3;
            r_out_data  <= r_byp_p3 ? r_bpd_p3 : w_norm;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_mode_p1  <= w_mode;
            r_neg_p1   <= w_neg;
            r_byp_p1   <= w_byp;
            r_bpd_p1   <= w_bpd;
            r_mag_p1   <= w_mag;
            r_mode_p2  <= r_mode_p1;
            r_neg_p2   <= r_neg_p1;
            r_byp_p2   <= r_byp_p1;
            r_bpd_p2   <= r_bpd_p1;
            r_y_p2     <= w_y;
            r_rsign_p3 <= w_rsign;
            r_byp_p3   <= r_byp_p2;
            r_bpd_p3   <= r_bpd_p2;
            r_r_p3     <= w_r;
        end
    end

endmodule

// File: tb/tb_fp_activation_pipe.sv
// Directed bench for fp_activation_pipe: per-mode vectors, special values,
// backpressure ordering/stability and asynchronous mid-stream reset.
module tb_fp_activation_pipe;
    import fp_act_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    fp_activation_pipe #(
        .FRAC_BITS   (16),
        .LEAKY_SHIFT (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Present one beat, then count edges (including the accepting one) until out_valid.
    task automatic run_single(input string tag, input logic [1:0] mode, input logic [31:0] din,
                              input logic [31:0] exp_v);
        int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = mode;
        in_data   = din;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'd4);
        check_eq(tag, out_data, exp_v);
    endtask

    logic [1:0]  bp_mode [8] = '{MODE_SIGMOID, MODE_TANH, MODE_RELU, MODE_LEAKY,
                                 MODE_SIGMOID, MODE_TANH, MODE_RELU, MODE_SIGMOID};
    logic [31:0] bp_in   [8] = '{32'h3F800000, 32'h3F000000, 32'h40200000, 32'hC0400000,
                                 32'hBF800000, 32'hBF000000, 32'hC0400000, 32'h7FA00000};
    logic [31:0] bp_exp  [8] = '{32'h3F400000, 32'h3F000000, 32'h40200000, 32'hBEC00000,
                                 32'h3E800000, 32'hBF000000, 32'h00000000, 32'h7FC00000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx, oidx, lat;
        logic acc, was_stalled;
        logic [31:0] held;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 2'd0;
        in_data   = 32'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        run_single("sig_zero",  MODE_SIGMOID, 32'h00000000, 32'h3F000000);
        run_single("sig_one",   MODE_SIGMOID, 32'h3F800000, 32'h3F400000);
        run_single("sig_mone",  MODE_SIGMOID, 32'hBF800000, 32'h3E800000);
        run_single("sig_eight", MODE_SIGMOID, 32'h41000000, 32'h3F800000);
        run_single("sig_1p5",   MODE_SIGMOID, 32'h3FC00000, 32'h3F500000);
        run_single("sig_three", MODE_SIGMOID, 32'h40400000, 32'h3F700000);
        run_single("sig_mhalf", MODE_SIGMOID, 32'hBF000000, 32'h3EC00000);
        run_single("sig_pinf",  MODE_SIGMOID, 32'h7F800000, 32'h3F800000);
        run_single("sig_ninf",  MODE_SIGMOID, 32'hFF800000, 32'h00000000);
        run_single("tanh_half", MODE_TANH,    32'h3F000000, 32'h3F000000);
        run_single("tanh_mhalf",MODE_TANH,    32'hBF000000, 32'hBF000000);
        run_single("tanh_ninf", MODE_TANH,    32'hFF800000, 32'hBF800000);
        run_single("tanh_two",  MODE_TANH,    32'h40000000, 32'h3F700000);
        run_single("tanh_zero", MODE_TANH,    32'h00000000, 32'h00000000);
        run_single("relu_neg",  MODE_RELU,    32'hC0400000, 32'h00000000);
        run_single("relu_pos",  MODE_RELU,    32'h40200000, 32'h40200000);
        run_single("leaky_neg", MODE_LEAKY,   32'hC0400000, 32'hBEC00000);
        run_single("leaky_pos", MODE_LEAKY,   32'h40200000, 32'h40200000);
        run_single("leaky_tiny",MODE_LEAKY,   32'h81000000, 32'h80000000);
        run_single("leaky_ninf",MODE_LEAKY,   32'hFF800000, 32'hFF800000);
        run_single("nan_sig",   MODE_SIGMOID, 32'h7FA00000, 32'h7FC00000);
        run_single("nan_tanh",  MODE_TANH,    32'h7FA00000, 32'h7FC00000);
        run_single("nan_relu",  MODE_RELU,    32'h7FA00000, 32'h7FC00000);
        run_single("nan_leaky", MODE_LEAKY,   32'h7FA00000, 32'h7FC00000);
        run_single("denorm_sig",MODE_SIGMOID, 32'h00000001, 32'h3F000000);

        // Backpressure: 8 back-to-back beats, out_ready low for cycles 6..10
        @(posedge clk); #1;
        idx = 0;
        oidx = 0;
        was_stalled = 1'b0;
        held = 32'd0;
        for (int c = 0; c < 60 && oidx < 8; c++) begin
            in_valid  = (idx < 8);
            in_mode   = bp_mode[idx & 7];
            in_data   = bp_in[idx & 7];
            out_ready = !(c >= 6 && c < 11);
            @(negedge clk);
            if (out_valid && !out_ready) begin
                check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
                if (was_stalled) check_eq("stall_hold", out_data, held);
                held = out_data;
                was_stalled = 1'b1;
            end else begin
                was_stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                check_eq($sformatf("bp_beat%0d", oidx), out_data, bp_exp[oidx]);
                oidx++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("bp_count", 32'(oidx), 32'd8);
        repeat (2) @(posedge clk);
        #1;
        check_eq("bp_no_dup", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset with three beats in flight
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_mode  = MODE_RELU;
        for (int k = 0; k < 3; k++) begin
            in_data = 32'h3F800000 + 32'(k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check_eq("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("arst_out_data", out_data, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_eq("arst_in_ready", {31'd0, in_ready}, 32'd1);
        run_single("post_rst", MODE_SIGMOID, 32'h41000000, 32'h3F800000);
        lat = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) lat++;
        end
        check_eq("post_rst_no_stale", 32'(lat), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_activation_pipe.md
Name: fp_activation_pipe

Overview:
- Pipelined, multi-mode activation unit for IEEE-754 single-precision values; successor to the single-function combinational-style sigmoid.
- Adds mode select (sigmoid, tanh, ReLU, leaky ReLU), a parametrised internal fixed-point precision, valid/ready streaming with backpressure, and defined special-value handling.
- Sits between the neuron MAC/accumulate stage and the next layer's input buffer.

Parameters:
- FRAC_BITS, 16, fractional bits of the internal fixed-point datapath; legal range 8..23.
- LEAKY_SHIFT, 3, leaky-ReLU negative slope is 2^-LEAKY_SHIFT; legal range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_mode  in  2  function select: 0 sigmoid, 1 tanh, 2 ReLU, 3 leaky ReLU.
- in_data  in  32  operand x, IEEE-754 single.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts a result.
- out_data  out  32  f(x), IEEE-754 single.

Behaviour:
- Reset: all stage valid bits 0, out_valid=0, out_data=0; in_ready=1 after reset. Reset mid-stream discards all in-flight beats.
- Four register stages; latency is exactly 4 cycles from an accepted beat to out_valid when out_ready is held 1.
- Global stall: advance = ~out_valid | out_ready; in_ready = advance. A beat is accepted when in_valid & in_ready.
- With out_valid=1 and out_ready=0, all stages and out_data hold unchanged. Bubbles propagate as valid=0. Throughput is 1 beat/cycle.
- S1, unpack/classify:
  - NaN: pass through as canonical quiet NaN 0x7FC00000 in every mode.
  - ±inf: saturates; sigmoid gives 1.0/0.0, tanh gives ±1.0, ReLU gives +inf/0, leaky gives +inf/-inf.
  - Denormals and zero are treated as +0.
  - For sigmoid/tanh, |x| (tanh: |2x|) is truncated to unsigned fixed point with 3 integer bits and FRAC_BITS fractional bits. Magnitudes ≥5.0 clamp to 5.0.
- S2, PLAN piecewise-linear on magnitude m, shifts and adds only:
  - m<1: y = m/4 + 0.5
  - 1≤m<2.375: y = m/8 + 0.625
  - 2.375≤m<5: y = m/32 + 0.84375
  - m≥5: y = 1.0
- S3, post-process:
  - Sigmoid, negative x: y = 1 − y.
  - tanh: r = 2y − 1, sign taken from x.
  - Zero result becomes +0.
- S4, pack: leading-one detect and normalise the fixed magnitude; truncate, no rounding. Results are exact for FRAC_BITS ≤ 23.
- ReLU and leaky ReLU bypass the fixed datapath in float, but still traverse all 4 stages.
  - ReLU: x if x≥0, else +0.
  - Leaky: negative x has its exponent reduced by LEAKY_SHIFT; if the exponent reaches ≤0, flush to -0.
- in_mode is sampled with the beat and travels with it. Mixed modes in flight are legal.

Decomposition:
- Package fp_act_pkg holds:
  - mode encodings (MODE_SIGMOID=0, MODE_TANH=1, MODE_RELU=2, MODE_LEAKY=3);
  - the float field widths and bias 127;
  - PLAN breakpoints and offsets as FRAC_BITS-scaled constants;
  - QNAN=0x7FC00000 and ONE=0x3F800000.
- One sub-module, fp_fix_normalize: a combinational leading-one detector plus fixed-to-float packer used in S4.

Test Plan:
- Sigmoid, out_ready=1: in 0x00000000, 0x3F800000 (1.0), 0xBF800000 (-1.0), 0x41000000 (8.0) → outputs 0x3F000000, 0x3F400000, 0x3E800000, 0x3F800000, each exactly 4 cycles after acceptance.
- tanh: 0x3F000000 (0.5) → 0x3F000000; 0xBF000000 → 0xBF000000; 0xFF800000 (-inf) → 0xBF800000.
- ReLU and leaky: ReLU 0xC0400000 (-3.0) → 0x00000000, ReLU 0x40200000 → 0x40200000; leaky 0xC0400000 → 0xBEC00000 (-0.375).
- Special values: 0x7FA00000 (sNaN) in every mode → 0x7FC00000; denormal 0x00000001 in sigmoid → 0x3F000000.
- Backpressure: stream 8 back-to-back mixed-mode beats, hold out_ready=0 for 5 cycles mid-stream. Required: in_ready=0 while stalled, no beat lost or duplicated, order preserved, out_data stable while stalled.
- Reset mid-stream: assert reset_n=0 with 3 beats in flight → out_valid=0 immediately (asynchronous). After release, the first new beat emerges after 4 cycles with no stale data.
